imem_fetch: RTL and testbench
=============================

Name: imem_fetch

Overview:
- Instruction-fetch initiator for the combinational instruction memory (`imem`); it drives the read address and captures the returned word.
- Holds the program counter and fetches one 32-bit word per cycle.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from execute, which flush the buffer and reload the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and treated as 0.
- DEPTH, 2, FIFO entries of {pc, instr}; legal values are 2..8, and the count register is $clog2(DEPTH+1) bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_addr  out  32  IMEM read address; equals the PC register, combinationally.
- imem_data  in  32  IMEM read data; combinational function of imem_addr, sampled in the same cycle.
- redirect_valid  in  1  load a new PC and flush the FIFO.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- out_valid  out  1  FIFO head is valid for decode.
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  address of the head instruction.
- out_instr  out  32  head instruction word.

Behaviour:
- Reset (rst high at a clock edge):
  - pc <= {RESET_PC[31:2],2'b00}; FIFO count, read pointer and write pointer <= 0.
  - No fetch occurs in that cycle.
  - Outputs while in reset: out_valid=0, out_pc=0, out_instr=0, imem_addr=pc.
  - Reset asserted mid-stream discards every buffered entry and any pending redirect.
- Signal definitions:
  - pop = out_valid && out_ready.
  - out_valid = (count != 0) && !redirect_valid.
  - The redirect-to-out_valid combinational path is intentional: decode never sees a wrong-path instruction in the redirect cycle.
- Fetch:
  - fetch = !rst && !redirect_valid && (count < DEPTH || pop).
  - On fetch: push {pc, imem_data} at the write pointer, then pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - No fetch means pc holds and imem_addr is still driven.
- Latency:
  - A word read in cycle N appears on out_* in cycle N+1 at the earliest.
  - With out_ready held high, throughput is 1 instruction per cycle and the FIFO holds exactly 1 entry.
- Head stability: while out_valid && !out_ready, out_pc and out_instr stay constant.
- Full:
  - count == DEPTH with no pop: no fetch, pc holds.
  - count == DEPTH with a pop in the same cycle: push and pop together, count unchanged.
- Empty: out_valid=0; out_pc and out_instr are don't-care, but the bench must not check them.
- Redirect (redirect_valid=1, takes priority over everything except rst):
  - count <= 0 and pointers <= 0; pc <= {redirect_pc[31:2],2'b00}.
  - No push; no pop, since out_valid is forced to 0.
  - The first instruction from the target appears one cycle after the first non-redirect cycle.
  - Back-to-back redirects: the last one wins.
- Pointer and count arithmetic:
  - Pointers wrap modulo DEPTH.
  - count <= count + fetch - pop; it never exceeds DEPTH and never underflows.
- PC range: the PC is not range-checked; IMEM decodes only addr[9:2], so PCs of 1024 and above alias.

Test Plan:
- Reset then free-run:
  - Stimulus: imem words 0..3 = 0x11,0x22,0x33,0x44; RESET_PC=0; out_ready=1.
  - Required: out_valid first high in the cycle after rst drops; (out_pc,out_instr) = (0,0x11),(4,0x22),(8,0x33),(C,0x44) on consecutive cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after the first valid.
  - Required: out_valid=1, out_pc=0 and out_instr=0x11 stable throughout; count saturates at 2; imem_addr holds 0x8; on release, 0x11,0x22,0x33 stream without gaps or duplicates.
- Redirect:
  - Stimulus: FIFO full (pc 0,4 buffered); redirect_valid=1 with redirect_pc=0x102 for one cycle.
  - Required: out_valid=0 that cycle; the next cycle imem_addr=0x100; the cycle after, out_pc=0x100 with the word at index 64; entries 0 and 4 never delivered.
- Redirect with out_ready=1:
  - Stimulus: redirect asserted while the head is pending and out_ready=1.
  - Required: no transfer reported (out_valid=0); the head is dropped.
- PC wrap:
  - Stimulus: redirect_pc=0xFFFF_FFFC with out_ready=1.
  - Required: out_pc sequence 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004; instr = imem[255], imem[0], imem[1].
- Reset mid-stream:
  - Stimulus: rst pulsed for 1 cycle while count=2 and redirect_valid=1.
  - Required: the next cycle has out_valid=0 and imem_addr=RESET_PC; the stream restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/imem_fetch.sv
// Instruction-fetch front end: drives the PC into the combinational IMEM,
// buffers {pc, instr} pairs in a small FIFO and hands them to decode.
module imem_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [31:0]   RESET_PC_A = RESET_PC & ~32'h3;

   logic [31:0]   pc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count;
   logic [31:0]   redirect_tgt;
   logic          fetch, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign redirect_tgt = redirect_pc & ~32'h3;
   assign imem_addr    = pc;

   // Redirect masks the head in the same cycle so decode never takes a wrong-path word.
   assign out_valid = !rst && (count != '0) && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign fetch     = !rst && !redirect_valid && ((count < DEPTH_C) || pop);
   assign out_pc    = rst ? '0 : pc_mem[rptr];
   assign out_instr = rst ? '0 : instr_mem[rptr];

   always_ff @(posedge clk) begin
      if (fetch) begin
         pc_mem[wptr]    <= pc;
         instr_mem[wptr] <= imem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= RESET_PC_A;
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else if (redirect_valid) begin
         pc    <= redirect_tgt;
         count <= '0;
         rptr  <= '0;
         wptr  <= '0;
      end else begin
         if (fetch) begin
            wptr <= ptr_inc(wptr);
            pc   <= pc + 32'd4;
         end
         if (pop) rptr <= ptr_inc(rptr);
         case ({fetch, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: reset, streaming, backpressure, redirects,
// PC wrap and mid-stream reset against hand-computed expectations.
module tb_imem_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   logic [31:0] mem [256];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[9:2]];

   imem_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      chk({tag, "_v"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_pc"}, out_pc, pc);
      chk({tag, "_in"}, out_instr, instr);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      cyc(); cyc();
      // reset state
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);

      // free run
      rst = 1'b0; #1;
      chk("run_first_v", {31'b0, out_valid}, 32'd0);
      chk("run_first_addr", imem_addr, 32'd0);
      cyc(); chk_head("run0", 32'h0, 32'h11);
      cyc(); chk_head("run1", 32'h4, 32'h22);
      cyc(); chk_head("run2", 32'h8, 32'h33);
      cyc(); chk_head("run3", 32'hC, 32'h44);
      chk("run_addr", imem_addr, 32'h10);

      // backpressure
      rst = 1'b1; cyc();
      rst = 1'b0; cyc();
      out_ready = 1'b0; #1;
      chk_head("bp1", 32'h0, 32'h11);
      chk("bp1_addr", imem_addr, 32'h4);
      for (int k = 2; k <= 5; k++) begin
         cyc();
         chk_head($sformatf("bp%0d", k), 32'h0, 32'h11);
         chk($sformatf("bp%0d_addr", k), imem_addr, 32'h8);
         chk($sformatf("bp%0d_cnt", k), 32'(dut.count), 32'd2);
      end
      cyc(); out_ready = 1'b1; #1;
      chk_head("rel0", 32'h0, 32'h11);
      cyc(); chk_head("rel1", 32'h4, 32'h22);
      cyc(); chk_head("rel2", 32'h8, 32'h33);

      // redirect from full FIFO
      rst = 1'b1; cyc();
      rst = 1'b0; cyc();
      out_ready = 1'b0; cyc();
      redirect_valid = 1'b1; redirect_pc = 32'h102; #1;
      chk("redir_v", {31'b0, out_valid}, 32'd0);
      cyc(); redirect_valid = 1'b0; #1;
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_v2", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b1;
      cyc(); chk_head("redir_h0", 32'h100, mem[64]);
      cyc(); chk_head("redir_h1", 32'h104, mem[65]);

      // redirect with out_ready high, back-to-back: last wins
      redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
      chk("rr_v", {31'b0, out_valid}, 32'd0);
      cyc(); redirect_pc = 32'h200; #1;
      chk("rr_addr1", imem_addr, 32'h300);
      chk("rr_v1", {31'b0, out_valid}, 32'd0);
      cyc(); redirect_valid = 1'b0; #1;
      chk("rr_addr2", imem_addr, 32'h200);
      cyc(); chk_head("rr_h0", 32'h200, mem[128]);

      // PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cyc(); redirect_valid = 1'b0; #1;
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      cyc(); chk_head("wrap0", 32'hFFFF_FFFC, mem[255]);
      cyc(); chk_head("wrap1", 32'h0, 32'h11);
      cyc(); chk_head("wrap2", 32'h4, 32'h22);

      // reset mid-stream with a pending redirect
      out_ready = 1'b0; cyc();
      chk("mid_cnt", 32'(dut.count), 32'd2);
      rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400; #1;
      chk("mid_rst_v", {31'b0, out_valid}, 32'd0);
      cyc(); rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; #1;
      chk("mid_v", {31'b0, out_valid}, 32'd0);
      chk("mid_addr", imem_addr, 32'h0);
      cyc(); chk_head("mid_h0", 32'h0, 32'h11);
      cyc(); chk_head("mid_h1", 32'h4, 32'h22);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
